cam_line_fifo: RTL and testbench
================================

Name: cam_line_fifo

Overview:
Parametrised capture FIFO between the camera pixel interface (pclk/href/vsync/din) and downstream consumers such as the colour classifier and frame buffer writer. It accepts pixel bytes only during active line time and tags each stored word with start-of-frame and start-of-line markers. It reports level, full/empty, per-frame overflow/underflow and a line count. Single clock domain (pclk); the reader runs on pclk.

Parameters:
DATA_W, 9, pixel data width in bits
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)
AFULL_LVL, 12, level at or above which afull asserts
LINE_W, 9, width of line counter

Ports:
pclk  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-low reset; reset==0 at a pclk edge clears all state
href  input  1  line valid from camera
vsync  input  1  frame sync; high = vertical blanking
din  input  DATA_W  pixel byte
rd  input  1  read strobe, one word per cycle
dout  output  DATA_W+2  {sof, sol, data}; registered
dout_valid  output  1  one-cycle pulse, dout updated this cycle
empty  output  1  level==0
full  output  1  level==2**DEPTH_LOG2
afull  output  1  level>=AFULL_LVL
level  output  DEPTH_LOG2+1  current occupancy
overflow  output  1  sticky; write dropped because FIFO full
underflow  output  1  sticky; rd while empty
line_cnt  output  LINE_W  href rising edges since last vsync falling edge

Behaviour:
- Reset (reset==0 at edge): pointers, level, dout, dout_valid, overflow, underflow, line_cnt, and internal href_q/vsync_q/sof_pend all 0. empty=1, full=0, afull=0.
- Edge detection: href_q and vsync_q are the previous-cycle registered samples. sol_edge = href & ~href_q; sof_edge = vsync_q & ~vsync.
- sof_edge sets sof_pend=1, clears line_cnt to 0, clears overflow and underflow.
- vsync rising edge (vsync & ~vsync_q) does not change flags.
- Write request: href==1 && vsync==0. Stored word = {sof_pend, sol_edge, din}. sof_pend clears on the cycle its word is accepted.
- sol_edge with vsync==0 increments line_cnt. Increment saturates at all-ones.
- Write accepted if not full, or if full and a valid read occurs in the same cycle. Otherwise the word is dropped, overflow is set, and sof_pend is kept.
- Read: rd && !empty. The word is registered to dout on that edge, and dout_valid=1 for that one cycle.
- Read when rd && empty: dout holds, dout_valid=0, underflow set.
- Latency: a word written at edge N is readable at edge N+1; empty deasserts after edge N.
- Simultaneous read and write: level unchanged. On an empty FIFO the read is not serviced that cycle: underflow is set and the write is accepted.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. level is tracked explicitly, so full and empty are unambiguous.
- Status outputs (empty, full, afull) are combinational from the level register.

Optional Feature:
Macro FRAME_DROP_EN.
- Defined: the first dropped write sets drop_frame. While drop_frame=1, all writes for the remainder of the frame are discarded even if space frees up. drop_frame clears on sof_edge. This guarantees no partial lines reach downstream.
- Undefined: only individual words are dropped while full; writes resume as soon as space exists.
- In both cases overflow behaves identically.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with href=1 and vsync=0. Result: level=0, empty=1, dout=0, line_cnt=0, no writes.
2. Frame start: vsync 1->0, then href=1 for 3 cycles with din="h","o","l", then rd=1 for 3 cycles. Result: dout sequence {1,1,"h"}, {0,0,"o"}, {0,0,"l"}, with dout_valid high each cycle, and line_cnt=1.
3. Fill: write 16 words with no rd. Result: full=1, afull asserted from level 12. A 17th write is dropped and overflow=1. A subsequent read returns word 1 with intact order.
4. Full with simultaneous rd/wr: level stays 16, no overflow, and the new word appears after the 15 older words.
5. Underflow: rd=1 on empty. Result: underflow=1, dout_valid=0. Next sof_edge clears underflow.
6. FRAME_DROP_EN: overflow mid-line, read 4 words, continue href. Result: no further writes until vsync 1->0. With the macro undefined, 4 more words are accepted.

Source files
------------

// File: rtl/cam_line_fifo.sv
// cam_line_fifo: capture FIFO between the camera pixel port and downstream
// consumers. Only pixels seen during active line time (href high, vsync low)
// are stored. Each stored word is tagged {sof, sol, data}. The block also
// reports occupancy, sticky per-frame overflow/underflow flags and a line count.
// Everything runs on the rising edge of pclk and uses a synchronous active-low reset.
//
// Optional feature: define FRAME_DROP_EN so that, after the first write is
// dropped for lack of space, the rest of that frame is discarded. This way no
// partial line reaches the consumers. With the macro undefined, only the
// individual words that meet a full FIFO are lost.

module cam_line_fifo #(
  parameter int DATA_W     = 9,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12,
  parameter int LINE_W     = 9
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  href,
  input  logic                  vsync,
  input  logic [DATA_W-1:0]     din,
  input  logic                  rd,
  output logic [DATA_W+1:0]     dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  output logic [LINE_W-1:0]     line_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AFULL_L  = AFULL_LVL[DEPTH_LOG2:0];

  logic [DATA_W+1:0]     mem_q [DEPTH];

  logic                  href_q, href_d;
  logic                  vsync_q, vsync_d;
  logic                  sof_pend_q, sof_pend_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DATA_W+1:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [LINE_W-1:0]     line_cnt_q, line_cnt_d;

  logic                  sol_edge;
  logic                  sof_edge;
  logic                  wr_req;
  logic                  rd_ok;
  logic                  rd_empty;
  logic                  level_full;
  logic                  space_ok;
  logic                  wr_ok;
  logic                  drop_full;
  logic [DATA_W+1:0]     wdata;

`ifdef FRAME_DROP_EN
  logic                  drop_frame_q, drop_frame_d;
`endif

  // Edge detection, request qualification and acceptance decisions
  always_comb begin
    sol_edge   = href & ~href_q;
    sof_edge   = vsync_q & ~vsync;
    wr_req     = href & ~vsync;
    rd_empty   = rd & (level_q == '0);
    rd_ok      = rd & (level_q != '0);
    level_full = (level_q == FULL_LVL);
    // a read in the same cycle frees the slot the write is about to take
    space_ok   = ~level_full | rd_ok;
    drop_full  = wr_req & ~space_ok;
`ifdef FRAME_DROP_EN
    wr_ok      = wr_req & space_ok & ~drop_frame_q;
`else
    wr_ok      = wr_req & space_ok;
`endif
    // a frame start seen this very cycle still tags the word being written
    wdata      = {sof_pend_q | sof_edge, sol_edge, din};
  end

  // Next-state computation for pointers, level, output word and frame flags
  always_comb begin
    href_d       = href;
    vsync_d      = vsync;

    sof_pend_d   = sof_pend_q | sof_edge;
    if (wr_ok) begin
      sof_pend_d = 1'b0;
    end

    line_cnt_d   = sof_edge ? '0 : line_cnt_q;
    if (sol_edge && !vsync && (line_cnt_d != '1)) begin
      line_cnt_d = line_cnt_d + LINE_W'(1);
    end

    overflow_d   = sof_edge ? 1'b0 : overflow_q;
    if (drop_full) begin
      overflow_d = 1'b1;
    end

    underflow_d  = sof_edge ? 1'b0 : underflow_q;
    if (rd_empty) begin
      underflow_d = 1'b1;
    end

    wr_ptr_d     = wr_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d     = rd_ok ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

    level_d      = level_q;
    if (wr_ok && !rd_ok) begin
      level_d    = level_q + LVL_W'(1);
    end else if (rd_ok && !wr_ok) begin
      level_d    = level_q - LVL_W'(1);
    end

    dout_d       = rd_ok ? mem_q[rd_ptr_q] : dout_q;
    dout_valid_d = rd_ok;

`ifdef FRAME_DROP_EN
    drop_frame_d = sof_edge ? 1'b0 : drop_frame_q;
    if (drop_full) begin
      drop_frame_d = 1'b1;
    end
`endif
  end

  // Storage array; contents need no reset because the pointers and level do
  always_ff @(posedge pclk) begin
    if (reset && wr_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge pclk) begin
    if (!reset) begin
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      sof_pend_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      line_cnt_q   <= '0;
`ifdef FRAME_DROP_EN
      drop_frame_q <= 1'b0;
`endif
    end else begin
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      sof_pend_q   <= sof_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      line_cnt_q   <= line_cnt_d;
`ifdef FRAME_DROP_EN
      drop_frame_q <= drop_frame_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign level      = level_q;
  assign empty      = (level_q == '0);
  assign full       = (level_q == FULL_LVL);
  assign afull      = (level_q >= AFULL_L);
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign line_cnt   = line_cnt_q;

endmodule

// File: tb/tb_cam_line_fifo.sv
// tb_cam_line_fifo: directed, table-driven bench for cam_line_fifo.
// Reset, frame/line tagging, read-out and underflow are covered by a vector table.
// Fill, full-with-read, overflow and post-overflow behaviour use hand-written
// sequences. Expectations follow FRAME_DROP_EN when that macro is defined.

module tb_cam_line_fifo;

  localparam int DATA_W     = 9;
  localparam int DEPTH_LOG2 = 4;
  localparam int AFULL_LVL  = 12;
  localparam int LINE_W     = 9;

  logic               pclk;
  logic               reset;
  logic               href;
  logic               vsync;
  logic [DATA_W-1:0]  din;
  logic               rd;
  logic [DATA_W+1:0]  dout;
  logic               dout_valid;
  logic               empty;
  logic               full;
  logic               afull;
  logic [DEPTH_LOG2:0] level;
  logic               overflow;
  logic               underflow;
  logic [LINE_W-1:0]  line_cnt;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic        rstN;
    logic        href;
    logic        vsync;
    logic [8:0]  din;
    logic        rd;
    logic [10:0] eDout;
    logic        eValid;
    logic [4:0]  eLevel;
    logic        eOv;
    logic        eUf;
    logic [8:0]  eLine;
  } vec_t;

  vec_t vecs [13];

  cam_line_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .AFULL_LVL (AFULL_LVL),
    .LINE_W    (LINE_W)
  ) dut (
    .pclk      (pclk),
    .reset     (reset),
    .href      (href),
    .vsync     (vsync),
    .din       (din),
    .rd        (rd),
    .dout      (dout),
    .dout_valid(dout_valid),
    .empty     (empty),
    .full      (full),
    .afull     (afull),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow),
    .line_cnt  (line_cnt)
  );

  // Free-running pixel clock
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Hard stop in case the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then let a rising edge pass and settle
  task automatic applyStimulus(input logic rstN, input logic h, input logic v,
                               input logic [8:0] d, input logic r);
    reset = rstN;
    href  = h;
    vsync = v;
    din   = d;
    rd    = r;
    @(posedge pclk);
    #1;
  endtask

  // Check all outputs; the status flags are derived from the expected level
  task automatic checkAll(input string tag, input logic [10:0] eDout, input logic eValid,
                          input logic [4:0] eLevel, input logic eOv, input logic eUf,
                          input logic [8:0] eLine);
    checkOutput({tag, ".dout"},       32'(dout),       32'(eDout));
    checkOutput({tag, ".dout_valid"}, 32'(dout_valid), 32'(eValid));
    checkOutput({tag, ".level"},      32'(level),      32'(eLevel));
    checkOutput({tag, ".empty"},      32'(empty),      32'(eLevel == 5'd0));
    checkOutput({tag, ".full"},       32'(full),       32'(eLevel == 5'd16));
    checkOutput({tag, ".afull"},      32'(afull),      32'(eLevel >= 5'd12));
    checkOutput({tag, ".overflow"},   32'(overflow),   32'(eOv));
    checkOutput({tag, ".underflow"},  32'(underflow),  32'(eUf));
    checkOutput({tag, ".line_cnt"},   32'(line_cnt),   32'(eLine));
  endtask

  // Main test sequence
  initial begin
    logic [10:0] holdDout;
    logic        dropMode;

`ifdef FRAME_DROP_EN
    dropMode = 1'b1;
`else
    dropMode = 1'b0;
`endif

    reset = 1'b0;
    href  = 1'b0;
    vsync = 1'b0;
    din   = '0;
    rd    = 1'b0;

    //            rstN href vs  din     rd   eDout    eV   eLvl eOv  eUf  eLine
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 9'h001, 1'b0, 11'h000, 1'b0, 5'd0, 1'b0, 1'b0, 9'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 9'h002, 1'b0, 11'h000, 1'b0, 5'd0, 1'b0, 1'b0, 9'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 11'h000, 1'b0, 5'd0, 1'b0, 1'b0, 9'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 11'h000, 1'b0, 5'd0, 1'b0, 1'b0, 9'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 9'h068, 1'b0, 11'h000, 1'b0, 5'd1, 1'b0, 1'b0, 9'd1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 9'h06F, 1'b0, 11'h000, 1'b0, 5'd2, 1'b0, 1'b0, 9'd1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 9'h06C, 1'b0, 11'h000, 1'b0, 5'd3, 1'b0, 1'b0, 9'd1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 11'h668, 1'b1, 5'd2, 1'b0, 1'b0, 9'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 11'h06F, 1'b1, 5'd1, 1'b0, 1'b0, 9'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 11'h06C, 1'b1, 5'd0, 1'b0, 1'b0, 9'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 11'h06C, 1'b0, 5'd0, 1'b0, 1'b1, 9'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 11'h06C, 1'b0, 5'd0, 1'b0, 1'b1, 9'd1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 11'h06C, 1'b0, 5'd0, 1'b0, 1'b0, 9'd0};

    $display("[TB] table vectors: reset, frame start, read-out, underflow");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].href, vecs[i].vsync, vecs[i].din, vecs[i].rd);
      checkAll($sformatf("vec%0d", i), vecs[i].eDout, vecs[i].eValid, vecs[i].eLevel,
               vecs[i].eOv, vecs[i].eUf, vecs[i].eLine);
    end

    $display("[TB] fill to full");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 9'(i), 1'b0);
      checkAll($sformatf("fill%0d", i), 11'h06C, 1'b0, 5'(i + 1), 1'b0, 1'b0, 9'd1);
    end

    $display("[TB] read and write together while full");
    applyStimulus(1'b1, 1'b1, 1'b0, 9'd16, 1'b1);
    checkAll("fullRdWr", 11'h600, 1'b1, 5'd16, 1'b0, 1'b0, 9'd1);

    $display("[TB] write while full is dropped");
    applyStimulus(1'b1, 1'b1, 1'b0, 9'd17, 1'b0);
    checkAll("drop", 11'h600, 1'b0, 5'd16, 1'b1, 1'b0, 9'd1);

    $display("[TB] drain in order");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 1'b1);
      checkAll($sformatf("drain%0d", i), {2'b00, 9'(i)}, 1'b1, 5'(16 - i), 1'b1, 1'b0, 9'd1);
    end
    holdDout = 11'h010;

    $display("[TB] new line after overflow in same frame");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 9'h100 + 9'(k), 1'b0);
      checkAll($sformatf("postDrop%0d", k), holdDout, 1'b0,
               dropMode ? 5'd0 : 5'(k + 1), 1'b1, 1'b0, 9'd2);
    end
    if (!dropMode) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 1'b1);
        checkAll($sformatf("postRead%0d", k), {1'b0, (k == 0), 9'h100 + 9'(k)}, 1'b1,
                 5'(3 - k), 1'b1, 1'b0, 9'd2);
      end
      holdDout = 11'h103;
    end

    $display("[TB] next frame clears flags and resumes writes");
    applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, 1'b0);
    checkAll("vsHigh", holdDout, 1'b0, 5'd0, 1'b1, 1'b0, 9'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 1'b0);
    checkAll("vsFall", holdDout, 1'b0, 5'd0, 1'b0, 1'b0, 9'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 9'h055, 1'b0);
    checkAll("newWrite", holdDout, 1'b0, 5'd1, 1'b0, 1'b0, 9'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 1'b1);
    checkAll("newRead", 11'h655, 1'b1, 5'd0, 1'b0, 1'b0, 9'd1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
